// File: rtl/zx48_pkg.sv
// Shared definitions for the ZX48 memory subsystem: grant codes and widths.
package zx48_pkg;

  localparam int unsigned AW_DEFAULT = 21;
  localparam int unsigned DW         = 8;
  localparam int unsigned WAIT_W     = 8;

  // SRAM grant owner for the current access slot.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_AUX  = 2'd3
  } gnt_e;

  // Saturating increment used by the aux starvation counter.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v,
                                                input logic [WAIT_W-1:0] lim);
    sat_inc = (v >= lim) ? v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/sram_arb_sel.sv
// Combinational priority selector: picks the owner of the next SRAM slot.
module sram_arb_sel
  import zx48_pkg::*;
(
  input  logic       i_slot_a,
  input  logic       i_vreq,
  input  logic       i_creq,
  input  logic       i_xreq,
  input  logic       i_starve,
  output logic [1:0] o_gnt_c
);

  // A slots favour video; B slots never grant video and let a starved aux jump the CPU.
  always_comb begin
    o_gnt_c = GNT_NONE;
    if (i_slot_a) begin
      if (i_vreq) begin
        o_gnt_c = GNT_VID;
      end else if (i_creq) begin
        o_gnt_c = GNT_CPU;
      end else if (i_xreq) begin
        o_gnt_c = GNT_AUX;
      end
    end else begin
      if (i_xreq && i_starve) begin
        o_gnt_c = GNT_AUX;
      end else if (i_creq) begin
        o_gnt_c = GNT_CPU;
      end else if (i_xreq) begin
        o_gnt_c = GNT_AUX;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-clock time-slot scheduler sharing one async 8-bit SRAM between video, CPU and aux.
module sram_arbiter
  import zx48_pkg::*;
#(
  parameter int unsigned AW           = AW_DEFAULT,
  parameter int unsigned AUX_MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          vReq,
  input  logic [AW-1:0] vA,
  output logic [7:0]    vDo,
  output logic          vAck,
  input  logic          cReq,
  input  logic          cWe,
  input  logic [AW-1:0] cA,
  input  logic [7:0]    cDi,
  output logic [7:0]    cDo,
  output logic          cAck,
  input  logic          xReq,
  input  logic          xWe,
  input  logic [AW-1:0] xA,
  input  logic [7:0]    xDi,
  output logic [7:0]    xDo,
  output logic          xAck,
  output logic [AW-1:0] ramA,
  output logic [7:0]    ramDo,
  output logic          ramDoe,
  input  logic [7:0]    ramDi,
  output logic          ramWe
);

  gnt_e              r_gnt;
  gnt_e              w_gnt_nxt;
  logic              r_h;
  logic              w_h_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic [AW-1:0]     r_ram_a;
  logic [AW-1:0]     w_ram_a_nxt;
  logic [7:0]        r_ram_do;
  logic [7:0]        w_ram_do_nxt;
  logic              r_ram_doe;
  logic              w_ram_doe_nxt;
  logic              r_ram_we;
  logic              w_ram_we_nxt;
  logic              r_v_ack;
  logic              w_v_ack_nxt;
  logic              r_c_ack;
  logic              w_c_ack_nxt;
  logic              r_x_ack;
  logic              w_x_ack_nxt;
  logic [7:0]        r_v_do;
  logic [7:0]        w_v_do_nxt;
  logic [7:0]        r_c_do;
  logic [7:0]        w_c_do_nxt;
  logic [7:0]        r_x_do;
  logic [7:0]        w_x_do_nxt;

  logic              w_bound;
  logic              w_slot_a;
  logic              w_vreq_m;
  logic              w_creq_m;
  logic              w_xreq_m;
  logic              w_starve;
  logic              w_sel_we;
  logic [1:0]        w_sel;

  // Slot framing: boundaries on every other edge; ce only matters at a boundary.
  assign w_bound  = ~r_h;
  assign w_slot_a = w_bound & ce;

  // The port finishing at this boundary still holds req in its ack clock; keep it out.
  assign w_vreq_m = vReq & (r_gnt != GNT_VID);
  assign w_creq_m = cReq & (r_gnt != GNT_CPU);
  assign w_xreq_m = xReq & (r_gnt != GNT_AUX);
  assign w_starve = (r_wait == WAIT_W'(AUX_MAX_WAIT));

  sram_arb_sel u_sel (
    .i_slot_a (w_slot_a),
    .i_vreq   (w_vreq_m),
    .i_creq   (w_creq_m),
    .i_xreq   (w_xreq_m),
    .i_starve (w_starve),
    .o_gnt_c  (w_sel)
  );

  // Next-state: complete the running access and launch the next one at each boundary.
  always_comb begin
    w_h_nxt       = ~r_h;
    w_gnt_nxt     = r_gnt;
    w_we_nxt      = r_we;
    w_wait_nxt    = r_wait;
    w_ram_a_nxt   = r_ram_a;
    w_ram_do_nxt  = r_ram_do;
    w_ram_doe_nxt = r_ram_doe;
    w_ram_we_nxt  = 1'b1;
    w_v_ack_nxt   = 1'b0;
    w_c_ack_nxt   = 1'b0;
    w_x_ack_nxt   = 1'b0;
    w_v_do_nxt    = r_v_do;
    w_c_do_nxt    = r_c_do;
    w_x_do_nxt    = r_x_do;
    w_sel_we      = 1'b0;

    if (w_bound) begin
      case (r_gnt)
        GNT_VID: begin
          w_v_ack_nxt = 1'b1;
          if (!r_we) w_v_do_nxt = ramDi;
        end
        GNT_CPU: begin
          w_c_ack_nxt = 1'b1;
          if (!r_we) w_c_do_nxt = ramDi;
        end
        GNT_AUX: begin
          w_x_ack_nxt = 1'b1;
          if (!r_we) w_x_do_nxt = ramDi;
        end
        default: ;
      endcase

      w_gnt_nxt = gnt_e'(w_sel);
      case (w_sel)
        GNT_VID: begin
          w_ram_a_nxt = vA;
        end
        GNT_CPU: begin
          w_ram_a_nxt = cA;
          w_sel_we    = cWe;
          if (cWe) w_ram_do_nxt = cDi;
        end
        GNT_AUX: begin
          w_ram_a_nxt = xA;
          w_sel_we    = xWe;
          if (xWe) w_ram_do_nxt = xDi;
        end
        default: ;
      endcase
      w_we_nxt      = w_sel_we;
      w_ram_doe_nxt = w_sel_we;

      if (w_sel == GNT_AUX) begin
        w_wait_nxt = '0;
      end else if (!w_slot_a && w_xreq_m) begin
        w_wait_nxt = sat_inc(r_wait, WAIT_W'(AUX_MAX_WAIT));
      end
    end else begin
      w_ram_we_nxt = ~((r_gnt != GNT_NONE) & r_we);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_h       <= 1'b0;
      r_gnt     <= GNT_NONE;
      r_we      <= 1'b0;
      r_wait    <= '0;
      r_ram_a   <= '0;
      r_ram_do  <= '0;
      r_ram_doe <= 1'b0;
      r_ram_we  <= 1'b1;
      r_v_ack   <= 1'b0;
      r_c_ack   <= 1'b0;
      r_x_ack   <= 1'b0;
      r_v_do    <= '0;
      r_c_do    <= '0;
      r_x_do    <= '0;
    end else begin
      r_h       <= w_h_nxt;
      r_gnt     <= w_gnt_nxt;
      r_we      <= w_we_nxt;
      r_wait    <= w_wait_nxt;
      r_ram_a   <= w_ram_a_nxt;
      r_ram_do  <= w_ram_do_nxt;
      r_ram_doe <= w_ram_doe_nxt;
      r_ram_we  <= w_ram_we_nxt;
      r_v_ack   <= w_v_ack_nxt;
      r_c_ack   <= w_c_ack_nxt;
      r_x_ack   <= w_x_ack_nxt;
      r_v_do    <= w_v_do_nxt;
      r_c_do    <= w_c_do_nxt;
      r_x_do    <= w_x_do_nxt;
    end
  end

  assign vDo    = r_v_do;
  assign vAck   = r_v_ack;
  assign cDo    = r_c_do;
  assign cAck   = r_c_ack;
  assign xDo    = r_x_do;
  assign xAck   = r_x_ack;
  assign ramA   = r_ram_a;
  assign ramDo  = r_ram_do;
  assign ramDoe = r_ram_doe;
  assign ramWe  = r_ram_we;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an ack/data scoreboard and a small SRAM model.
module tb_sram_arbiter;
  import zx48_pkg::*;

  localparam int unsigned AW = 21;

  logic          clock;
  logic          reset;
  logic          ce;
  logic          vReq;
  logic [AW-1:0] vA;
  logic [7:0]    vDo;
  logic          vAck;
  logic          cReq;
  logic          cWe;
  logic [AW-1:0] cA;
  logic [7:0]    cDi;
  logic [7:0]    cDo;
  logic          cAck;
  logic          xReq;
  logic          xWe;
  logic [AW-1:0] xA;
  logic [7:0]    xDi;
  logic [7:0]    xDo;
  logic          xAck;
  logic [AW-1:0] ramA;
  logic [7:0]    ramDo;
  logic          ramDoe;
  logic [7:0]    ramDi;
  logic          ramWe;

  logic [7:0] mem [0:31];

  typedef struct {
    logic [1:0] port;
    logic [7:0] data;
    logic       chk;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   edge_idx = 0;
  logic bh       = 1'b0;

  sram_arbiter #(.AW(AW), .AUX_MAX_WAIT(8)) dut (
    .clock (clock), .reset (reset), .ce (ce),
    .vReq (vReq), .vA (vA), .vDo (vDo), .vAck (vAck),
    .cReq (cReq), .cWe (cWe), .cA (cA), .cDi (cDi), .cDo (cDo), .cAck (cAck),
    .xReq (xReq), .xWe (xWe), .xA (xA), .xDi (xDi), .xDo (xDo), .xAck (xAck),
    .ramA (ramA), .ramDo (ramDo), .ramDoe (ramDoe), .ramDi (ramDi), .ramWe (ramWe)
  );

  assign ramDi = mem[ramA[16:12]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expect an ack from port p on the edge lat edges after the last one.
  task automatic push(input logic [1:0] p, input logic [7:0] d, input logic chk, input int lat);
    exp_t e;
    e.port = p;
    e.data = d;
    e.chk  = chk;
    e.due  = edge_idx + lat;
    q.push_back(e);
  endtask

  // One clock: advance, then at the falling edge model SRAM writes and score acks.
  task automatic tick();
    logic [2:0] exp_ack;
    exp_t       e;
    @(posedge clock);
    edge_idx++;
    bh = (reset == 1'b0) ? 1'b0 : ~bh;
    @(negedge clock);
    if (ramWe === 1'b0) mem[ramA[16:12]] = ramDo;
    exp_ack = 3'b000;
    if (q.size() > 0 && q[0].due == edge_idx) begin
      case (q[0].port)
        2'd1:    exp_ack = 3'b001;
        2'd2:    exp_ack = 3'b010;
        default: exp_ack = 3'b100;
      endcase
    end
    check($sformatf("ack@%0d", edge_idx), {29'd0, xAck, cAck, vAck}, {29'd0, exp_ack});
    if (q.size() > 0 && q[0].due == edge_idx) begin
      e = q.pop_front();
      if (e.chk) begin
        case (e.port)
          2'd1:    check($sformatf("vDo@%0d", edge_idx), {24'd0, vDo}, {24'd0, e.data});
          2'd2:    check($sformatf("cDo@%0d", edge_idx), {24'd0, cDo}, {24'd0, e.data});
          default: check($sformatf("xDo@%0d", edge_idx), {24'd0, xDo}, {24'd0, e.data});
        endcase
      end
    end
  endtask

  task automatic align();
    if (bh) tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[4] = 8'h5A;
    reset = 1'b0; ce = 1'b0;
    vReq = 1'b0; vA = '0;
    cReq = 1'b0; cWe = 1'b0; cA = '0; cDi = 8'h00;
    xReq = 1'b0; xWe = 1'b0; xA = '0; xDi = 8'h00;

    // Reset state
    tick(); tick(); tick();
    check("rst_ramWe", 32'(ramWe), 32'd1);
    check("rst_ramDoe", 32'(ramDoe), 32'd0);
    check("rst_ramA", 32'(ramA), 32'd0);
    check("rst_ramDo", 32'(ramDo), 32'd0);
    check("rst_vDo", 32'(vDo), 32'd0);
    reset = 1'b1;

    // Video only, A slot every 4 clocks
    vReq = 1'b1; vA = 21'h04000;
    for (int f = 0; f < 6; f++) begin
      ce = 1'b1; push(GNT_VID, 8'h5A, 1'b1, 3);
      tick(); check("vid_ramA", 32'(ramA), 32'h04000);
      check("vid_we0", 32'(ramWe), 32'd1);
      ce = 1'b0;
      tick(); check("vid_we1", 32'(ramWe), 32'd1);
      tick(); check("vid_we2", 32'(ramWe), 32'd1);
      tick(); check("vid_we3", 32'(ramWe), 32'd1);
    end
    vReq = 1'b0;

    // CPU write then read-back, no video
    cReq = 1'b1; cWe = 1'b1; cA = 21'h08000; cDi = 8'hA5;
    push(GNT_CPU, 8'h00, 1'b0, 3);
    tick();
    check("wr_e0_doe", 32'(ramDoe), 32'd1);
    check("wr_e0_a", 32'(ramA), 32'h08000);
    check("wr_e0_do", 32'(ramDo), 32'hA5);
    check("wr_e0_we", 32'(ramWe), 32'd1);
    tick();
    check("wr_e1_we", 32'(ramWe), 32'd0);
    check("wr_e1_doe", 32'(ramDoe), 32'd1);
    tick();
    check("wr_e2_we", 32'(ramWe), 32'd1);
    check("wr_e2_doe", 32'(ramDoe), 32'd0);
    cWe = 1'b0;
    push(GNT_CPU, 8'hA5, 1'b1, 4);
    tick(); check("rd_we_a", 32'(ramWe), 32'd1);
    tick(); check("rd_we_b", 32'(ramWe), 32'd1);
    check("rd_doe", 32'(ramDoe), 32'd0);
    tick(); check("rd_we_c", 32'(ramWe), 32'd1);
    tick();
    cReq = 1'b0;

    // Req held one clock into the ack cycle: mask blocks a second access
    align();
    cReq = 1'b1; cWe = 1'b0; cA = 21'h08000;
    push(GNT_CPU, 8'hA5, 1'b1, 3);
    tick(); tick(); tick();
    tick();
    cReq = 1'b0;
    tick(); tick(); tick(); tick();

    // All three requesting: V in A, C in B, aux forced after 8 lost B slots
    align();
    vReq = 1'b1; vA = 21'h04000;
    cReq = 1'b1; cWe = 1'b0; cA = 21'h08000;
    xReq = 1'b1; xWe = 1'b0; xA = 21'h04000;
    for (int f = 0; f < 18; f++) begin
      ce = 1'b1; push(GNT_VID, 8'h5A, 1'b1, 3);
      tick();
      ce = 1'b0;
      tick();
      if (f == 8 || f == 17) push(GNT_AUX, 8'h5A, 1'b1, 3);
      else                   push(GNT_CPU, 8'hA5, 1'b1, 3);
      tick(); tick();
    end
    vReq = 1'b0;
    push(GNT_CPU, 8'hA5, 1'b1, 3);
    tick();
    xReq = 1'b0;
    tick(); tick();
    cReq = 1'b0;
    tick(); tick();

    // Reset while ramWe is low abandons the write
    align();
    cReq = 1'b1; cWe = 1'b1; cA = 21'h10000; cDi = 8'h3C;
    tick(); check("ab_e0_doe", 32'(ramDoe), 32'd1);
    tick(); check("ab_e1_we", 32'(ramWe), 32'd0);
    reset = 1'b0;
    tick();
    check("ab_ramWe", 32'(ramWe), 32'd1);
    check("ab_ramDoe", 32'(ramDoe), 32'd0);
    check("ab_ramA", 32'(ramA), 32'd0);
    check("ab_ramDo", 32'(ramDo), 32'd0);
    check("ab_vDo", 32'(vDo), 32'd0);
    check("ab_cDo", 32'(cDo), 32'd0);
    check("ab_xDo", 32'(xDo), 32'd0);
    cReq = 1'b0; cWe = 1'b0;
    reset = 1'b1;

    // ce at an odd edge is ignored; the following boundary is a B slot
    ce = 1'b0;
    tick();
    ce = 1'b1; vReq = 1'b1; vA = 21'h04000;
    tick();
    ce = 1'b0;
    tick();
    check("odd_ce_ramA", 32'(ramA), 32'd0);
    tick();
    ce = 1'b1; push(GNT_VID, 8'h5A, 1'b1, 3);
    tick();
    check("a_slot_ramA", 32'(ramA), 32'h04000);
    ce = 1'b0;
    tick(); tick();
    vReq = 1'b0;
    tick(); tick();

    check("q_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Time-slot scheduler that shares the single external 8-bit asynchronous SRAM (ramA/ramD/ramWe) between three requesters: video fetch, Z80 CPU, and an auxiliary loader/DMA port (SD-to-RAM loader).
- Sits between the memory-map logic and the SRAM pins.
- Video gets a guaranteed slot aligned to the pixel clock enable. The CPU has priority over aux. Aux has a bounded-starvation guarantee.
- The top level instantiates the ramD tristate from ramDo/ramDoe.

Parameters:
- AW, 21, SRAM address width.
- AUX_MAX_WAIT, 8, number of lost B slots after which aux is forced to win the next B slot (range 1..255).

Ports:
- clock  in  1  system clock (28 MHz).
- reset  in  1  synchronous, active-low.
- ce  in  1  video phase strobe (ce70n), 1 clock in 4; marks an A slot.
- vReq  in  1  video read request (level).
- vA  in  AW  video address.
- vDo  out  8  video read data.
- vAck  out  1  video completion pulse.
- cReq  in  1  CPU request (level).
- cWe  in  1  CPU write when 1.
- cA  in  AW  CPU address.
- cDi  in  8  CPU write data.
- cDo  out  8  CPU read data.
- cAck  out  1  CPU completion pulse.
- xReq  in  1  aux request (level).
- xWe  in  1  aux write when 1.
- xA  in  AW  aux address.
- xDi  in  8  aux write data.
- xDo  out  8  aux read data.
- xAck  out  1  aux completion pulse.
- ramA  out  AW  SRAM address.
- ramDo  out  8  SRAM write data.
- ramDoe  out  1  drive ramD when 1.
- ramDi  in  8  SRAM read data.
- ramWe  out  1  SRAM write enable, active-low.

Behaviour:
- Reset (reset=0 at an edge), applied at the next edge regardless of state:
  - ramWe=1, ramDoe=0, ramA=0, ramDo=0.
  - All acks 0; vDo/cDo/xDo=0.
  - Slot phase bit h=0, aux wait counter=0, grant=NONE.
  - An access in flight is abandoned with no ack.
- Slot framing:
  - A slot boundary occurs every 2 clocks: edges where h=0. h toggles every clock.
  - A boundary is an A slot if ce=1 at that edge, otherwise a B slot.
  - ce at a non-boundary edge is ignored.
- Grant, registered at the boundary edge e0:
  - A slot: video if vReq, else CPU if cReq, else aux if xReq, else NONE.
  - B slot: aux if xReq and waitCnt==AUX_MAX_WAIT; else CPU if cReq; else aux if xReq; else NONE. Video is never granted in a B slot.
  - Completion mask: the port completing at this boundary is not eligible at this same boundary. This prevents a duplicate access while its req is still high in the ack cycle.
- Access, 2 clocks, e0..e2:
  - At e0, latch ramA from the granted port; for writes also latch ramDo and set ramDoe=1.
  - At e1, ramWe=0 if write. It is held for one clock and returns to 1 at e2.
  - At e2, for reads, capture ramDi into the port's Do register. Ports hold Do until that port's next read completes.
  - The port's Ack is 1 for exactly the clock following e2.
  - ramDoe drops at e2 unless the next grant is also a write.
  - With NONE granted: ramWe=1, ramDoe=0, ramA holds its last value.
- Handshake:
  - Requesters hold req, address and data stable until Ack.
  - Requesters must drop req, or present a new request, in the Ack clock.
  - Changing inputs before Ack is undefined.
- Aux wait counter:
  - Increments (saturating at AUX_MAX_WAIT) on each B-slot boundary where xReq=1 and aux is not granted.
  - Clears when aux is granted.
- Simultaneous events:
  - All three requesting at an A slot: video, then CPU at B, then aux at the next free slot.
  - A CPU request arriving at the same edge as a boundary is eligible at that boundary.

Decomposition:
- Shared package zx48_pkg:
  - Grant encoding: GNT_NONE=0, GNT_VID=1, GNT_CPU=2, GNT_AUX=3.
  - Default AW.
- One natural sub-module: sram_arb_sel, a combinational priority selector. Inputs: slot type, masked reqs, starvation flag. Output: grant code.
- The remainder (framing, latching, ack, counter) stays in sram_arbiter.

Test Plan:
- Reset released, ce every 4 clocks, only vReq=1, vA=0x04000, SRAM model returns 0x5A → ramWe stays 1; vAck pulses 3 clocks after each A boundary; vDo=0x5A; no B-slot video grants.
- cReq with cWe=1, cA=0x08000, cDi=0xA5, no video → ramDoe=1 and ramA=0x08000 at e0; ramWe=0 for exactly one clock; cAck one pulse; readback gives cDo=0xA5.
- vReq, cReq and xReq all held high continuously → order per frame is V (A), C (B); xAck is forced after exactly AUX_MAX_WAIT=8 lost B slots; waitCnt resets.
- cReq held one clock into its Ack cycle → no second CPU access at the adjacent boundary (mask); exactly one cAck.
- Write in flight, reset=0 on the edge where ramWe=0 → next edge ramWe=1, ramDoe=0, no cAck, all Do=0.
- ce asserted at an odd edge (h=1) → ignored; next boundary is a B slot; video is not granted there.
